// File: rtl/mult64_arbiter.sv
// Shares one registered multiplier among NREQ valid/ready requesters and routes products back by tag.
// Define MULT64_ARB_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.
module mult64_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 64,
    parameter int LAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]      rsp_c,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_c,
    output logic                    idle
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gidx;
    logic            found;
    logic            accept;
    int              pos;

    logic [LAT:0]    tv;
    logic [IW-1:0]   ti [0:LAT];
    logic [NREQ-1:0] rsp_vq;

`ifdef MULT64_ARB_RR_EN
    logic [IW-1:0]   ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        end
    end
`endif

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef MULT64_ARB_RR_EN
            pos = int'(ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
`else
            pos = k;
`endif
            if (!found && req_valid[pos]) begin
                found = 1'b1;
                gidx  = IW'(pos);
            end
        end
        if (!rst && found) grant[gidx] = 1'b1;
    end

    assign accept    = |grant;
    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (accept) begin
            mul_a <= req_a[int'(gidx)*WIDTH +: WIDTH];
            mul_b <= req_b[int'(gidx)*WIDTH +: WIDTH];
        end
    end

    // Tag pipe runs free; its depth lines the owner up with mul_c.
    always_ff @(posedge clk) begin
        if (rst) begin
            tv <= '0;
            for (int i = 0; i <= LAT; i++) ti[i] <= '0;
        end else begin
            tv[0] <= accept;
            ti[0] <= gidx;
            for (int i = 1; i <= LAT; i++) begin
                tv[i] <= tv[i-1];
                ti[i] <= ti[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vq <= '0;
            rsp_c  <= '0;
        end else if (tv[LAT]) begin
            rsp_vq <= {{(NREQ-1){1'b0}}, 1'b1} << ti[LAT];
            rsp_c  <= mul_c;
        end else begin
            rsp_vq <= '0;
        end
    end

    // A pulse already registered when reset arrives belongs to a discarded op.
    assign rsp_valid = rsp_vq & {NREQ{~rst}};
    assign idle      = ~(|tv) & ~accept;

endmodule

// File: doc/mult64_arbiter.md
# mult64_arbiter

Round-robin arbiter and sequencer that shares one registered `mult64` multiplier among `NREQ` requesters. Each requester uses a valid/ready handshake. The block grants at most one operand pair per cycle and registers it onto the multiplier inputs. A tag travels alongside each operation through a pipeline matched to the multiplier latency, and the block returns each product to the requester that issued it. It sits between the requester clients and the `mult64` instance and gives full throughput of one multiply per cycle.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 64: operand width; the product is `2*WIDTH`.
- `LAT`, 1: multiplier latency in cycles, from registered operands to valid `mul_c` (`mult64` = 1).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  one-hot grant; combinational from `req_valid` and arbiter state.
- `req_a`  in  NREQ*WIDTH  packed operands A; requester i uses slice [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH  packed operands B; same packing as `req_a`.
- `rsp_valid`  out  NREQ  one-hot, one-cycle pulse marking the product owner.
- `rsp_c`  out  2*WIDTH  product; valid only when `rsp_valid` != 0.
- `mul_a`, `mul_b`  out  WIDTH  registered operands to the multiplier.
- `mul_c`  in  2*WIDTH  multiplier product.
- `idle`  out  1  high when no operation is in flight and no grant occurs this cycle.

## Operation
- Grant: among requesters with `req_valid` high, the arbiter selects exactly one and raises only its `req_ready`.
  - If no requester is valid, `req_ready` is 0.
  - Requesters must not make `req_valid` depend on `req_ready`.
- Accept: a requester is accepted when its `req_valid` and `req_ready` are both high at a rising edge.
  - On accept, `mul_a`/`mul_b` load the granted operands.
  - With no accept, `mul_a`/`mul_b` hold their previous values.
- Tag pipeline: depth `LAT+1`; each stage holds {valid, index[clog2(NREQ)-1:0]}.
  - Stage 0 loads {accept, granted index}.
  - All stages shift every cycle, with no stall.
- Response: when the last tag stage is valid, the block registers `rsp_c <= mul_c` and `rsp_valid <= onehot(index)`. Otherwise `rsp_valid <= 0` and `rsp_c` holds its value.
- Responses cannot be back-pressured; requesters must consume `rsp_valid` pulses as they arrive.
- Products come back in accept order, and products for the same requester come back in issue order.
- Arithmetic: the product is unsigned `WIDTH` x `WIDTH` -> `2*WIDTH` with no truncation. The block passes `mul_c` through unmodified.
- `idle` = no valid tag stage and no accept this cycle.

## Timing
- Reset values: `mul_a`=0, `mul_b`=0, `rsp_c`=0, `rsp_valid`=0, all tag valids 0, RR pointer=0, `idle`=1.
  - `req_ready` is forced to 0 while `rst` is high.
- Latency: for an accept in cycle n:
  - `mul_a`/`mul_b` are valid in cycle n+1.
  - `mul_c` is valid in cycle n+1+LAT.
  - `rsp_valid`/`rsp_c` are valid in cycle n+2+LAT; with LAT=1 this is n+3.
- Throughput: one accept per cycle; back-to-back accepts give back-to-back responses.
- Reset mid-operation: all in-flight tags are discarded and no `rsp_valid` is produced for them. The first grant after reset follows the reset pointer value of 0.
- Simultaneous accept and response in the same cycle is normal pipelined behaviour and does not conflict.

## Configuration
- `MULT64_ARB_RR_EN` defined: round-robin arbitration.
  - The pointer starts at 0. After each accept, the pointer is set to granted index + 1, modulo `NREQ`.
  - The search runs from the pointer upward and wraps around.
  - No requester that stays valid waits more than `NREQ-1` cycles.
- Undefined: fixed priority; the lowest valid index always wins, no pointer register is built, and starvation of higher indices is allowed.

## Test plan
- Single op, `MULT64_ARB_RR_EN` defined: req0 sends a=2, b=3, accepted in cycle n -> `rsp_valid`=0001 in cycle n+3 only, `rsp_c`=6, `idle` back to 1 in cycle n+3.
- Round-robin full load: all four requesters hold valid with a=i+1, b=10 -> grants 0,1,2,3,0,... on consecutive cycles; responses 10,20,30,40 with one-hot owners in the same order, one per cycle.
- Fixed priority (macro undefined): req0 and req2 held valid for 5 cycles -> `req_ready[2]`=0 throughout; five responses, all to req0.
- Extremes, one per cycle, from req3:
  - 0xFFFFFFFFFFFFFFFF^2 -> 0xFFFFFFFFFFFFFFFE0000000000000001.
  - 0x8000000000000000^2 -> 0x40000000000000000000000000000000.
  - 0xAAAA..AA x 0x5555..55 -> 0x38E38E38E38E38E31C71C71C71C71C72.
- Reset mid-flight: three accepts in cycles n..n+2, `rst` high in cycle n+3 -> no `rsp_valid` ever for those ops; `idle`=1 after reset; next grant with all valid goes to req0.
- Single streaming requester: only req1 valid for 8 cycles with random operands -> accepted every cycle, 8 consecutive correct responses to req1 in issue order.
